parser_multi_seg: RTL and testbench

- Parametrised successor to the single-configuration header parser at the head of the RMT pipeline.
- Captures up to NUM_SEGS beats of packet header from the AXI-Stream input and looks up a per-tenant parse-action entry, indexed by VLAN ID.
- Extracts up to NUM_ACT fields into 2B/4B/6B PHV containers and presents the PHV to stage 0 with a valid/ready handshake.
- Beats beyond the header window are consumed and dropped. An inline write port loads the action table.

---
 rtl/parser_multi_seg.sv | 180 ++++++++++++++++++
 tb/tb_parser_multi_seg.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parser_multi_seg.sv
// Header parser: captures up to NUM_SEGS beats, looks up a per-VLAN action entry, emits a PHV 3 cycles after tlast.
// Define PARSER_OUT_PORT_OVERRIDE_EN to force tuser[31:24] to DBG_OUT_PORT in the emitted metadata.
module parser_multi_seg #(
  parameter int         C_S_AXIS_DATA_WIDTH  = 256,
  parameter int         C_S_AXIS_TUSER_WIDTH = 128,
  parameter int         NUM_SEGS             = 4,
  parameter int         NUM_ACT              = 10,
  parameter int         NUM_CONT             = 8,
  parameter int         TBL_AW               = 5,
  parameter int         META_LEN             = 256,
  parameter int         PKT_HDR_LEN          = NUM_CONT*96+META_LEN,
  parameter logic [7:0] DBG_OUT_PORT         = 8'h04
) (
  input  logic                              axis_clk,
  input  logic                              areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic                              parser_valid,
  output logic [PKT_HDR_LEN-1:0]            pkt_hdr_vec,
  input  logic                              stg_ready_in,
  input  logic                              tbl_wr_en,
  input  logic [TBL_AW-1:0]                 tbl_wr_addr,
  input  logic [NUM_ACT*16-1:0]             tbl_wr_data
);

  localparam int DW        = C_S_AXIS_DATA_WIDTH;
  localparam int HDR_W     = NUM_SEGS*DW;
  localparam int HDR_BYTES = HDR_W/8;
  localparam int CNT_W     = $clog2(NUM_SEGS)+1;

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_SKIP, S_LOOKUP, S_EXTRACT, S_OUTPUT} state_t;

  state_t                              state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [HDR_W-1:0]                    hdr_q, hdr_d;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]     tuser_q, tuser_d;
  logic [NUM_CONT-1:0][15:0]           c2_q, c2_d;
  logic [NUM_CONT-1:0][31:0]           c4_q, c4_d;
  logic [NUM_CONT-1:0][47:0]           c6_q, c6_d;
  logic [NUM_ACT*16-1:0]               tbl_mem [2**TBL_AW];
  logic [NUM_ACT*16-1:0]               tbl_rd_q;
  logic [11:0]                         vlan_id;
  logic [TBL_AW-1:0]                   tbl_rd_addr;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]     tuser_out;
  logic [7:0]                          hdr_bytes [256];
  logic [15:0]                         act_w;
  logic [7:0]                          base;
  logic [47:0]                         fld;
  logic                                beat_acc;

  assign beat_acc    = s_axis_tvalid && s_axis_tready;
  assign vlan_id     = hdr_q[116+:12];
  assign tbl_rd_addr = vlan_id[TBL_AW+3:4];

  always_ff @(posedge axis_clk) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (beat_acc) begin
        if (s_axis_tlast)       state_d = S_LOOKUP;
        else if (NUM_SEGS == 1) state_d = S_SKIP;
        else                    state_d = S_CAPTURE;
      end
      S_CAPTURE: if (beat_acc) begin
        if (s_axis_tlast)                        state_d = S_LOOKUP;
        else if (cnt_q == CNT_W'(NUM_SEGS-1))    state_d = S_SKIP;
      end
      S_SKIP:    if (beat_acc && s_axis_tlast) state_d = S_LOOKUP;
      S_LOOKUP:  state_d = S_EXTRACT;
      S_EXTRACT: state_d = S_OUTPUT;
      S_OUTPUT:  if (stg_ready_in) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = (state_q == S_IDLE) || (state_q == S_CAPTURE) || (state_q == S_SKIP);
    parser_valid  = (state_q == S_OUTPUT);
  end

  always_comb begin
    hdr_d   = hdr_q;
    tuser_d = tuser_q;
    cnt_d   = cnt_q;
    if (beat_acc && state_q == S_IDLE) begin
      hdr_d           = '0;
      hdr_d[DW-1:0]   = s_axis_tdata;
      tuser_d         = s_axis_tuser;
      cnt_d           = CNT_W'(1);
    end else if (beat_acc && state_q == S_CAPTURE) begin
      for (int s = 0; s < NUM_SEGS; s++)
        if (CNT_W'(s) == cnt_q) hdr_d[DW*s+:DW] = s_axis_tdata;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Byte view of the header window, zero-padded so offset+5 never leaves the array.
  always_comb begin
    for (int k = 0; k < 256; k++)       hdr_bytes[k] = '0;
    for (int k = 0; k < HDR_BYTES; k++) hdr_bytes[k] = hdr_q[8*k+:8];
  end

  // Actions are applied in ascending index order so the highest index wins a shared container.
  always_comb begin
    c2_d  = c2_q;
    c4_d  = c4_q;
    c6_d  = c6_q;
    act_w = '0;
    base  = '0;
    fld   = '0;
    if (state_q == S_EXTRACT) begin
      c2_d = '0;
      c4_d = '0;
      c6_d = '0;
      for (int i = 0; i < NUM_ACT; i++) begin
        act_w = tbl_rd_q[16*(NUM_ACT-1-i)+:16];
        base  = {1'b0, act_w[12:6]};
        fld   = {hdr_bytes[base], hdr_bytes[base+8'd1], hdr_bytes[base+8'd2],
                 hdr_bytes[base+8'd3], hdr_bytes[base+8'd4], hdr_bytes[base+8'd5]};
        if (act_w[0] && (int'(act_w[3:1]) < NUM_CONT)) begin
          case (act_w[5:4])
            2'b01:   c2_d[act_w[3:1]] = fld[47:32];
            2'b10:   c4_d[act_w[3:1]] = fld[47:16];
            2'b11:   c6_d[act_w[3:1]] = fld;
            default: ;
          endcase
        end
      end
    end else if (state_q == S_OUTPUT && stg_ready_in) begin
      c2_d = '0;
      c4_d = '0;
      c6_d = '0;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      cnt_q   <= '0;
      hdr_q   <= '0;
      tuser_q <= '0;
      c2_q    <= '0;
      c4_q    <= '0;
      c6_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      tuser_q <= tuser_d;
      c2_q    <= c2_d;
      c4_q    <= c4_d;
      c6_q    <= c6_d;
    end
  end

  // Write and read in the same cycle: the read sees the pre-write contents.
  always_ff @(posedge axis_clk) begin
    if (tbl_wr_en) tbl_mem[tbl_wr_addr] <= tbl_wr_data;
    tbl_rd_q <= tbl_mem[tbl_rd_addr];
  end

`ifdef PARSER_OUT_PORT_OVERRIDE_EN
  assign tuser_out = {tuser_q[C_S_AXIS_TUSER_WIDTH-1:32], DBG_OUT_PORT, tuser_q[23:0]};
  logic unused_ok;
  assign unused_ok = ^{s_axis_tkeep, tbl_rd_q, tuser_q[31:24]};
`else
  assign tuser_out = tuser_q;
  logic unused_ok;
  assign unused_ok = ^{s_axis_tkeep, tbl_rd_q, DBG_OUT_PORT};
`endif

  assign pkt_hdr_vec = {c6_q, c4_q, c2_q, META_LEN'({vlan_id, 1'b0, tuser_out})};

endmodule

// File: tb/tb_parser_multi_seg.sv
// Scoreboard bench for parser_multi_seg: expected PHVs queued at send time, compared when parser_valid rises.
module tb_parser_multi_seg;
  localparam int NUM_ACT = 10;
  localparam int NUM_CONT = 8;
  localparam int PHV_W = 1024;

  logic                 axis_clk = 1'b0;
  logic                 areset;
  logic [255:0]         s_axis_tdata;
  logic [127:0]         s_axis_tuser;
  logic [31:0]          s_axis_tkeep;
  logic                 s_axis_tvalid;
  logic                 s_axis_tlast;
  logic                 s_axis_tready;
  logic                 parser_valid;
  logic [PHV_W-1:0]     pkt_hdr_vec;
  logic                 stg_ready_in;
  logic                 tbl_wr_en;
  logic [4:0]           tbl_wr_addr;
  logic [NUM_ACT*16-1:0] tbl_wr_data;

  int n_run = 0;
  int n_fail = 0;
  int stalls;
  logic [PHV_W-1:0]      exp_q [$];
  logic [7:0]            pkt_bytes [256];
  logic [NUM_ACT*16-1:0] tbl_m [32];

  always #5 axis_clk = ~axis_clk;

  parser_multi_seg dut (
    .axis_clk(axis_clk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .parser_valid(parser_valid), .pkt_hdr_vec(pkt_hdr_vec), .stg_ready_in(stg_ready_in),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data)
  );

  function automatic logic [15:0] act(input int off, input int typ, input int idx);
    return {3'b000, 7'(off), 2'(typ), 3'(idx), 1'b1};
  endfunction

  function automatic logic [NUM_ACT*16-1:0] put_act(input logic [NUM_ACT*16-1:0] e, input int i,
                                                    input logic [15:0] a);
    logic [NUM_ACT*16-1:0] r;
    r = e;
    r[16*(NUM_ACT-1-i)+:16] = a;
    return r;
  endfunction

  // Per container: scan actions from highest index down; the first valid match defines the value.
  function automatic logic [PHV_W-1:0] model(input logic [127:0] tu);
    logic [11:0]  vlan;
    logic [159:0] e;
    logic [767:0] c;
    logic [15:0]  a;
    logic [47:0]  v;
    logic [127:0] tuo;
    int           off;
    bit           hit;
    vlan = {pkt_bytes[15], pkt_bytes[14][7:4]};
    e = tbl_m[vlan[8:4]];
    c = '0;
    for (int t = 1; t <= 3; t++) begin
      for (int ci = 0; ci < NUM_CONT; ci++) begin
        hit = 1'b0;
        for (int i = NUM_ACT-1; i >= 0; i--) begin
          a = e[16*(NUM_ACT-1-i)+:16];
          if (!hit && a[0] && int'(a[5:4]) == t && int'(a[3:1]) == ci) begin
            hit = 1'b1;
            v = '0;
            off = int'(a[12:6]);
            for (int j = 0; j < 2*t; j++)
              v = {v[39:0], (off + j < 128) ? pkt_bytes[off+j] : 8'h00};
            case (t)
              1:       c[16*ci+:16] = v[15:0];
              2:       c[128+32*ci+:32] = v[31:0];
              default: c[384+48*ci+:48] = v;
            endcase
          end
        end
      end
    end
`ifdef PARSER_OUT_PORT_OVERRIDE_EN
    tuo = {tu[127:32], 8'h04, tu[23:0]};
`else
    tuo = tu;
`endif
    return {c, 256'({vlan, 1'b0, tuo})};
  endfunction

  task automatic new_pkt(input int nbeats, input bit rnd);
    for (int k = 0; k < 256; k++) pkt_bytes[k] = 8'h00;
    if (rnd) for (int k = 0; k < nbeats*32; k++) pkt_bytes[k] = 8'($urandom);
  endtask

  task automatic set_vlan(input logic [11:0] v);
    pkt_bytes[15] = v[11:4];
    pkt_bytes[14][7:4] = v[3:0];
  endtask

  task automatic tbl_write(input int addr, input logic [NUM_ACT*16-1:0] d);
    tbl_wr_en = 1'b1;
    tbl_wr_addr = 5'(addr);
    tbl_wr_data = d;
    tbl_m[addr] = d;
    @(posedge axis_clk); #1;
    tbl_wr_en = 1'b0;
  endtask

  task automatic send_pkt(input int nbeats, input logic [127:0] tu, input bit do_last);
    int guard;
    stalls = 0;
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < 32; k++) s_axis_tdata[8*k+:8] = pkt_bytes[32*b+k];
      s_axis_tuser = tu;
      s_axis_tvalid = 1'b1;
      s_axis_tlast = do_last && (b == nbeats-1);
      @(negedge axis_clk);
      guard = 0;
      while (!s_axis_tready && guard < 100) begin
        stalls++;
        guard++;
        @(negedge axis_clk);
      end
      n_run++;
      if (s_axis_tready !== 1'b1) begin
        n_fail++;
        $display("FAIL send_timeout beat %0d: tready=%b, required 1", b, s_axis_tready);
      end
      @(posedge axis_clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge axis_clk);
      lat++;
    end while (!parser_valid && lat < 50);
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge axis_clk);
    @(negedge axis_clk);
    n_run++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready: got %b, required 1", s_axis_tready); end
    n_run++; if (parser_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", parser_valid); end
    n_run++; if (pkt_hdr_vec !== '0) begin n_fail++; $display("FAIL reset_phv: got %h, required 0", pkt_hdr_vec); end
    @(posedge axis_clk); #1;
    areset = 1'b0;
    for (int a = 0; a < 32; a++) tbl_write(a, '0);
  endtask

  task automatic test_basic();
    logic [PHV_W-1:0] exp;
    logic [127:0] tu;
    int lat;
    tbl_write(1, put_act('0, 0, act(0, 3, 0)));
    new_pkt(2, 1'b0);
    pkt_bytes[0] = 8'h11; pkt_bytes[1] = 8'h22; pkt_bytes[2] = 8'h33;
    pkt_bytes[3] = 8'h44; pkt_bytes[4] = 8'h55; pkt_bytes[5] = 8'h66;
    set_vlan(12'h010);
    tu = {32'hdeadbeef, 32'h0badf00d, 32'h12345678, 32'h00a1b2c3};
    exp_q.push_back(model(tu));
    send_pkt(2, tu, 1'b1);
    wait_valid(lat);
    exp = exp_q.pop_front();
    n_run++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d, required 3", lat); end
    n_run++; if (pkt_hdr_vec !== exp) begin n_fail++; $display("FAIL basic_phv: got %h, required %h", pkt_hdr_vec[1023:256], exp[1023:256]); end
    n_run++; if (pkt_hdr_vec[640+:48] !== 48'h112233445566) begin n_fail++; $display("FAIL basic_6b0: got %h, required 112233445566", pkt_hdr_vec[640+:48]); end
    n_run++; if ({pkt_hdr_vec[1023:688], pkt_hdr_vec[639:256]} !== '0) begin n_fail++; $display("FAIL basic_others: nonzero containers, required all 0"); end
    @(posedge axis_clk); #1;
    @(negedge axis_clk);
    n_run++; if (parser_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b, required 0", parser_valid); end
    n_run++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL basic_tready_back: got %b, required 1", s_axis_tready); end
    @(posedge axis_clk); #1;
  endtask

  task automatic test_skip();
    logic [PHV_W-1:0] exp;
    logic [127:0] tu;
    logic [47:0] c61;
    logic [NUM_ACT*16-1:0] e;
    int lat;
    e = put_act('0, 0, act(124, 3, 1));
    e = put_act(e, 1, act(96, 2, 2));
    e = put_act(e, 2, act(40, 1, 0));
    tbl_write(2, e);
    new_pkt(6, 1'b1);
    set_vlan(12'h02c);
    tu = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(model(tu));
    send_pkt(6, tu, 1'b1);
    n_run++; if (stalls !== 0) begin n_fail++; $display("FAIL skip_tready: stall cycles %0d, required 0", stalls); end
    wait_valid(lat);
    exp = exp_q.pop_front();
    c61 = pkt_hdr_vec[688+:48];
    n_run++; if (lat !== 3) begin n_fail++; $display("FAIL skip_latency: got %0d, required 3", lat); end
    n_run++; if (pkt_hdr_vec !== exp) begin n_fail++; $display("FAIL skip_phv: got %h, required %h", pkt_hdr_vec[1023:256], exp[1023:256]); end
    n_run++; if (c61[15:0] !== 16'h0000) begin n_fail++; $display("FAIL skip_window_edge: got %h, required 0000", c61[15:0]); end
    @(posedge axis_clk); #1;
  endtask

  task automatic test_offset_tail();
    logic [PHV_W-1:0] exp;
    logic [127:0] tu;
    int lat;
    tbl_write(3, put_act('0, 4, act(126, 2, 5)));
    new_pkt(4, 1'b1);
    set_vlan(12'h03f);
    pkt_bytes[126] = 8'hab;
    pkt_bytes[127] = 8'hcd;
    tu = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(model(tu));
    send_pkt(4, tu, 1'b1);
    wait_valid(lat);
    exp = exp_q.pop_front();
    n_run++; if (pkt_hdr_vec[544+:32] !== 32'habcd0000) begin n_fail++; $display("FAIL tail_4b5: got %h, required abcd0000", pkt_hdr_vec[544+:32]); end
    n_run++; if (pkt_hdr_vec !== exp) begin n_fail++; $display("FAIL tail_phv: got %h, required %h", pkt_hdr_vec[1023:256], exp[1023:256]); end
    @(posedge axis_clk); #1;
  endtask

  task automatic test_priority();
    logic [PHV_W-1:0] exp;
    logic [127:0] tu;
    logic [NUM_ACT*16-1:0] e;
    int lat;
    e = put_act('0, 2, act(20, 1, 3));
    e = put_act(e, 7, act(30, 1, 3));
    tbl_write(4, e);
    new_pkt(2, 1'b1);
    set_vlan(12'h041);
    pkt_bytes[20] = 8'h20; pkt_bytes[21] = 8'h21;
    pkt_bytes[30] = 8'h30; pkt_bytes[31] = 8'h31;
    tu = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(model(tu));
    send_pkt(2, tu, 1'b1);
    wait_valid(lat);
    exp = exp_q.pop_front();
    n_run++; if (pkt_hdr_vec[304+:16] !== 16'h3031) begin n_fail++; $display("FAIL prio_2b3: got %h, required 3031", pkt_hdr_vec[304+:16]); end
    n_run++; if (pkt_hdr_vec !== exp) begin n_fail++; $display("FAIL prio_phv: got %h, required %h", pkt_hdr_vec[1023:256], exp[1023:256]); end
    @(posedge axis_clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [PHV_W-1:0] exp;
    logic [PHV_W-1:0] held;
    logic [127:0] tua, tub;
    logic [NUM_ACT*16-1:0] e;
    int lat;
    e = put_act('0, 0, act(0, 1, 0));
    e = put_act(e, 1, act(6, 2, 1));
    tbl_write(6, e);
    tbl_write(7, put_act('0, 3, act(17, 3, 2)));
    stg_ready_in = 1'b0;
    new_pkt(1, 1'b1);
    set_vlan(12'h065);
    tua = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(model(tua));
    send_pkt(1, tua, 1'b1);
    wait_valid(lat);
    exp = exp_q.pop_front();
    held = pkt_hdr_vec;
    n_run++; if (lat !== 3) begin n_fail++; $display("FAIL bp_latency: got %0d, required 3", lat); end
    n_run++; if (held !== exp) begin n_fail++; $display("FAIL bp_phv_a: got %h, required %h", held[1023:256], exp[1023:256]); end
    new_pkt(3, 1'b1);
    set_vlan(12'h07a);
    tub = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(model(tub));
    @(posedge axis_clk); #1;
    for (int k = 0; k < 32; k++) s_axis_tdata[8*k+:8] = pkt_bytes[k];
    s_axis_tuser = tub;
    s_axis_tvalid = 1'b1;
    s_axis_tlast = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge axis_clk);
      n_run++; if ({parser_valid, s_axis_tready} !== 2'b10) begin n_fail++; $display("FAIL bp_hold_ctrl cycle %0d: valid,tready=%b, required 10", c, {parser_valid, s_axis_tready}); end
      n_run++; if (pkt_hdr_vec !== held) begin n_fail++; $display("FAIL bp_hold_phv cycle %0d: PHV changed while stalled", c); end
    end
    @(posedge axis_clk); #1;
    stg_ready_in = 1'b1;
    send_pkt(3, tub, 1'b1);
    wait_valid(lat);
    exp = exp_q.pop_front();
    n_run++; if (lat !== 3) begin n_fail++; $display("FAIL bp_latency_b: got %0d, required 3", lat); end
    n_run++; if (pkt_hdr_vec !== exp) begin n_fail++; $display("FAIL bp_phv_b: got %h, required %h", pkt_hdr_vec[1023:256], exp[1023:256]); end
    n_run++; if ({pkt_hdr_vec[256+:16], pkt_hdr_vec[416+:32]} !== 48'h0) begin n_fail++; $display("FAIL bp_fresh: stale containers %h, required 0", {pkt_hdr_vec[256+:16], pkt_hdr_vec[416+:32]}); end
    @(posedge axis_clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [PHV_W-1:0] exp;
    logic [127:0] tu;
    logic [47:0] want;
    int lat;
    tbl_write(5, put_act('0, 9, act(10, 3, 7)));
    new_pkt(3, 1'b1);
    set_vlan(12'h05f);
    tu = {$urandom, $urandom, $urandom, $urandom};
    send_pkt(2, tu, 1'b0);
    areset = 1'b1;
    @(posedge axis_clk); #1;
    areset = 1'b0;
    @(negedge axis_clk);
    n_run++; if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tready: got %b, required 1", s_axis_tready); end
    n_run++; if (parser_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b, required 0", parser_valid); end
    n_run++; if (pkt_hdr_vec !== '0) begin n_fail++; $display("FAIL rst_mid_phv: got nonzero, required 0"); end
    @(posedge axis_clk); #1;
    new_pkt(2, 1'b1);
    set_vlan(12'h050);
    tu = {$urandom, $urandom, $urandom, $urandom};
    want = {pkt_bytes[10], pkt_bytes[11], pkt_bytes[12], pkt_bytes[13], pkt_bytes[14], pkt_bytes[15]};
    exp_q.push_back(model(tu));
    send_pkt(2, tu, 1'b1);
    wait_valid(lat);
    exp = exp_q.pop_front();
    n_run++; if (lat !== 3) begin n_fail++; $display("FAIL rst_mid_latency: got %0d, required 3", lat); end
    n_run++; if (pkt_hdr_vec[976+:48] !== want) begin n_fail++; $display("FAIL rst_mid_6b7: got %h, required %h", pkt_hdr_vec[976+:48], want); end
    n_run++; if (pkt_hdr_vec !== exp) begin n_fail++; $display("FAIL rst_mid_phv: got %h, required %h", pkt_hdr_vec[1023:256], exp[1023:256]); end
    @(posedge axis_clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1;
    s_axis_tdata = '0;
    s_axis_tuser = '0;
    s_axis_tkeep = '1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    stg_ready_in = 1'b1;
    tbl_wr_en = 1'b0;
    tbl_wr_addr = '0;
    tbl_wr_data = '0;
    test_reset();
    test_basic();
    test_skip();
    test_offset_tail();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
